// File: rtl/l1_miss_ctrl.sv
// L1 miss handler: optional victim writeback, line refill, then tag/valid install.
// Holds busy high for the whole miss so the core pipeline stays stalled.
module l1_miss_ctrl #(
  parameter int WAY_NUM    = 4,
  parameter int IDX_WIDTH  = 7,
  parameter int TAG_WIDTH  = 21,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_BEATS = 4,
  localparam int BEAT_W    = $clog2(LINE_BEATS),
  localparam int ADDR_W    = TAG_WIDTH + IDX_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  miss_req,
  input  logic [IDX_WIDTH-1:0]  miss_idx,
  input  logic [TAG_WIDTH-1:0]  miss_tag,
  input  logic [WAY_NUM-1:0]    miss_way_vect,
  input  logic                  miss_evict,
  input  logic [TAG_WIDTH-1:0]  evict_tag,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_req_val,
  input  logic                  mem_req_ack,
  output logic                  mem_req_we,
  output logic [ADDR_W-1:0]     mem_req_addr,
  output logic [BEAT_W-1:0]     mem_req_beat,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_rsp_val,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  output logic                  arr_rd_en,
  output logic                  arr_wr_en,
  output logic [IDX_WIDTH-1:0]  arr_idx,
  output logic [WAY_NUM-1:0]    arr_way_vect,
  output logic [BEAT_W-1:0]     arr_beat,
  output logic [DATA_WIDTH-1:0] arr_wdata,
  input  logic [DATA_WIDTH-1:0] arr_rdata,
  output logic                  tag_wr_en,
  output logic [TAG_WIDTH-1:0]  tag_wr_data,
  output logic                  err
);

  typedef enum logic [2:0] {
    IDLE,
    WB_RD,
    WB_LAT,
    WB_SEND,
    RD_REQ,
    RD_DATA,
    UPD
  } state_e;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);

  state_e                state_q, state_d;
  logic [BEAT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic [WAY_NUM-1:0]    way_q, way_d;
  logic [TAG_WIDTH-1:0]  evict_tag_q, evict_tag_d;
  logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
  logic                  err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      tag_q       <= '0;
      way_q       <= '0;
      evict_tag_q <= '0;
      wb_data_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      tag_q       <= tag_d;
      way_q       <= way_d;
      evict_tag_q <= evict_tag_d;
      wb_data_q   <= wb_data_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    tag_d        = tag_q;
    way_d        = way_q;
    evict_tag_d  = evict_tag_q;
    wb_data_d    = wb_data_q;
    // A refill beat is only legal while the line is being fetched.
    err_d        = err_q | (mem_rsp_val && (state_q != RD_DATA));

    busy         = 1'b0;
    done         = 1'b0;
    mem_req_val  = 1'b0;
    mem_req_we   = 1'b0;
    mem_req_addr = '0;
    mem_req_beat = '0;
    mem_wdata    = '0;
    arr_rd_en    = 1'b0;
    arr_wr_en    = 1'b0;
    arr_idx      = '0;
    arr_way_vect = '0;
    arr_beat     = '0;
    arr_wdata    = '0;
    tag_wr_en    = 1'b0;
    tag_wr_data  = '0;

    if (state_q != IDLE) begin
      busy         = 1'b1;
      arr_idx      = idx_q;
      arr_way_vect = way_q;
    end

    unique case (state_q)
      IDLE: begin
        if (miss_req) begin
          idx_d       = miss_idx;
          tag_d       = miss_tag;
          way_d       = miss_way_vect;
          evict_tag_d = evict_tag;
          cnt_d       = '0;
          state_d     = miss_evict ? WB_RD : RD_REQ;
        end
      end
      WB_RD: begin
        arr_rd_en = 1'b1;
        arr_beat  = cnt_q;
        state_d   = WB_LAT;
      end
      WB_LAT: begin
        wb_data_d = arr_rdata;
        state_d   = WB_SEND;
      end
      WB_SEND: begin
        mem_req_val  = 1'b1;
        mem_req_we   = 1'b1;
        mem_req_addr = {evict_tag_q, idx_q};
        mem_req_beat = cnt_q;
        mem_wdata    = wb_data_q;
        if (mem_req_ack) begin
          // Counter wraps back to zero after the last beat, ready for the refill.
          cnt_d   = cnt_q + 1'b1;
          state_d = (cnt_q == LAST_BEAT) ? RD_REQ : WB_RD;
        end
      end
      RD_REQ: begin
        mem_req_val  = 1'b1;
        mem_req_addr = {tag_q, idx_q};
        if (mem_req_ack) begin
          cnt_d   = '0;
          state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (mem_rsp_val) begin
          arr_wr_en = 1'b1;
          arr_beat  = cnt_q;
          arr_wdata = mem_rsp_data;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) begin
            state_d = UPD;
          end
        end
      end
      UPD: begin
        tag_wr_en   = 1'b1;
        tag_wr_data = tag_q;
        done        = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign err = err_q;

endmodule
